// File: rtl/hex_display_scan.sv
`timescale 1ns/1ps
// Purpose: time-multiplexed N-digit common-anode hex 7-segment scanner with a 1-cycle anti-ghost blank per slot.
// Latency: load sample edge -> new segments on the following edge (2 edges); all outputs registered.
// Backpressure: none; a load is accepted every cycle, there is no busy indication.
// Optional build macro: HEX_SCAN_LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 and dp digits always shown).
module hex_display_scan #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            S,
    output logic                  dp
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PS_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    // Reject out-of-range configurations at elaboration time.
    generate
        if ((N_DIGITS < 1) || (N_DIGITS > 8)) begin : g_bad_n_digits
            $error("hex_display_scan: N_DIGITS must be in 1..8");
        end
        if (REFRESH_DIV < 2) begin : g_bad_refresh_div
            $error("hex_display_scan: REFRESH_DIV must be >= 2");
        end
    endgenerate

    // Active-low segment pattern {a,b,c,d,e,f,g}; anything unrecognised blanks the digit.
    function automatic logic [6:0] enc(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    logic [PS_W-1:0]       r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_shadow;
    logic [N_DIGITS-1:0]   r_dp_shadow;
    logic [N_DIGITS-1:0]   r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic                  w_tick;
    logic [3:0]            w_nibble;
    logic                  w_dp_sel;
    logic [N_DIGITS-1:0]   w_an_lit;
    logic                  w_suppress;

    // The last prescaler count of each slot is the blank cycle and the scan advance point.
    assign w_tick = (r_presc == PS_LAST);

    // Slot prescaler: free-running 0..REFRESH_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    // Scan index: step to the next digit at the end of each slot, wrapping after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            if (r_idx == IDX_LAST) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Shadow capture: the whole value and dp mask are taken together so a lit slot never mixes old and new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_dp_shadow <= '0;
        end else if (load) begin
            r_shadow    <= value;
            r_dp_shadow <= dp_in;
        end
    end

    // Select the nibble, dp bit and anode pattern of the digit being scanned.
    always_comb begin
        w_nibble = 4'h0;
        w_dp_sel = 1'b0;
        w_an_lit = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble    = r_shadow[4*k +: 4];
                w_dp_sel    = r_dp_shadow[k];
                w_an_lit[k] = 1'b0;
            end
        end
    end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] w_msd;

    // Most significant nonzero digit; 0 when the shadow is all zeros so digit 0 always shows.
    always_comb begin
        w_msd = '0;
        for (int k = 1; k < N_DIGITS; k++) begin
            if (r_shadow[4*k +: 4] != 4'h0) begin
                w_msd = IDX_W'(k);
            end
        end
    end

    // Leading zeros above the msd go dark for their whole slot unless their decimal point is requested.
    assign w_suppress = (r_idx > w_msd) && !w_dp_sel;
`else
    assign w_suppress = 1'b0;
`endif

    // Output register: blank on the slot's last cycle (and for suppressed digits), otherwise drive the current digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else if (w_tick || w_suppress) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_lit;
            r_seg <= enc(w_nibble);
            r_dp  <= ~w_dp_sel;
        end
    end

    assign an = r_an;
    assign S  = r_seg;
    assign dp = r_dp;

endmodule

// File: tb/tb_hex_display_scan.sv
`timescale 1ns/1ps
// Bench for hex_display_scan: a 4-digit/4-cycle instance driven from a vector table,
// plus a 1-digit/2-cycle instance swept through all nibbles; reset corner by hand.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_hex_display_scan;

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dpi;
        logic [3:0]  an;
        logic [6:0]  s;
        logic        dp;
    } vec_t;

    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] ENC [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [3:0] AN_OF [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk;
    logic        rst;
    logic        load4;
    logic [15:0] value4;
    logic [3:0]  dp_in4;
    logic [3:0]  an4;
    logic [6:0]  seg4;
    logic        dp4;
    logic        load1;
    logic [3:0]  value1;
    logic [0:0]  dp_in1;
    logic [0:0]  an1;
    logic [6:0]  seg1;
    logic        dp1;

    int total = 0;
    int bad   = 0;
    vec_t tab[$];

    hex_display_scan #(.N_DIGITS(4), .REFRESH_DIV(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .load  (load4),
        .value (value4),
        .dp_in (dp_in4),
        .an    (an4),
        .S     (seg4),
        .dp    (dp4)
    );

    hex_display_scan #(.N_DIGITS(1), .REFRESH_DIV(2)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .load  (load1),
        .value (value1),
        .dp_in (dp_in1),
        .an    (an1),
        .S     (seg1),
        .dp    (dp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [15:0] v, input logic [3:0] di,
                       input logic [3:0] a, input logic [6:0] s, input logic d);
        vec_t r;
        r.ld = ld; r.val = v; r.dpi = di; r.an = a; r.s = s; r.dp = d;
        tab.push_back(r);
    endtask

    task automatic add_slot(input logic [15:0] v, input logic [3:0] a, input logic [6:0] s, input logic d);
        repeat (3) add(1'b0, v, 4'h0, a, s, d);
        add(1'b0, v, 4'h0, 4'hF, OFF, 1'b1);
    endtask

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            load4  = tab[i].ld;
            value4 = tab[i].val;
            dp_in4 = tab[i].dpi;
            step();
            check($sformatf("%s row%0d an", tag, i), 32'(an4),  32'(tab[i].an));
            check($sformatf("%s row%0d S",  tag, i), 32'(seg4), 32'(tab[i].s));
            check($sformatf("%s row%0d dp", tag, i), 32'(dp4),  32'(tab[i].dp));
        end
        load4 = 1'b0;
    endtask

    initial begin
        int m_scan_end;
        int m_lz_end;
        logic [6:0] prev_s;

        // Scan after reset with shadow=0: digits 0..3 then wrap to 0.
        for (int d = 0; d < 4; d++) begin
            if (d == 0 || !LZB) add_slot(16'h0, AN_OF[d], ENC[0], 1'b1);
            else                add_slot(16'h0, 4'hF, OFF, 1'b1);
        end
        add(1'b0, 16'h0, 4'h0, 4'b1110, 7'b0000001, 1'b1);
        // Load A5C3 with dp on digit 2; old zero still shown on the load edge.
        add(1'b1, 16'hA5C3, 4'b0100, 4'b1110, 7'b0000001, 1'b1);
        add(1'b0, 16'hFFFF, 4'b1111, 4'b1110, 7'b0000110, 1'b1);
        add(1'b0, 16'hFFFF, 4'b1111, 4'hF, OFF, 1'b1);
        add_slot(16'hFFFF, 4'b1101, 7'b0110001, 1'b1);
        add_slot(16'hFFFF, 4'b1011, 7'b0100100, 1'b0);
        add_slot(16'hFFFF, 4'b0111, 7'b0001000, 1'b1);
        add(1'b0, 16'hFFFF, 4'h0, 4'b1110, 7'b0000110, 1'b1);
        // 1111 loaded mid-slot, then 2222 loaded on the tick edge.
        add(1'b1, 16'h1111, 4'h0, 4'b1110, 7'b0000110, 1'b1);
        add(1'b0, 16'h1111, 4'h0, 4'b1110, 7'b1001111, 1'b1);
        add(1'b1, 16'h2222, 4'h0, 4'hF, OFF, 1'b1);
        add(1'b0, 16'h2222, 4'h0, 4'b1101, 7'b0010010, 1'b1);
        add(1'b0, 16'h2222, 4'h0, 4'b1101, 7'b0010010, 1'b1);
        add(1'b0, 16'h0, 4'h0, 4'b1101, 7'b0010010, 1'b1);
        add(1'b0, 16'h0, 4'h0, 4'hF, OFF, 1'b1);
        add(1'b0, 16'h0, 4'h0, 4'b1011, 7'b0010010, 1'b1);
        m_scan_end = tab.size();
        // After reset restart: load 0040 with dp on digit 3.
        add(1'b1, 16'h0040, 4'b1000, 4'b1110, 7'b0000001, 1'b1);
        add(1'b0, 16'h0040, 4'h0, 4'b1110, 7'b0000001, 1'b1);
        add(1'b0, 16'h0040, 4'h0, 4'hF, OFF, 1'b1);
        add_slot(16'h0040, 4'b1101, 7'b1001100, 1'b1);
        if (LZB) add_slot(16'h0040, 4'hF, OFF, 1'b1);
        else     add_slot(16'h0040, 4'b1011, 7'b0000001, 1'b1);
        add_slot(16'h0040, 4'b0111, 7'b0000001, 1'b0);
        m_lz_end = tab.size();

        rst = 1'b1;
        load4 = 1'b0; value4 = 16'h0; dp_in4 = 4'h0;
        load1 = 1'b0; value1 = 4'h0;  dp_in1 = 1'b0;
        step();
        step();
        check("reset an4", 32'(an4),  32'hF);
        check("reset S4",  32'(seg4), 32'(OFF));
        check("reset dp4", 32'(dp4),  32'h1);
        check("reset an1", 32'(an1),  32'h1);
        check("reset S1",  32'(seg1), 32'(OFF));
        rst = 1'b0;

        run_rows(0, m_scan_end, "scan");

        // Reset asserted while digit 2 is lit: outputs must drop before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst an", 32'(an4),  32'hF);
        check("async_rst S",  32'(seg4), 32'(OFF));
        check("async_rst dp", 32'(dp4),  32'h1);
        step();
        rst = 1'b0;
        step();
        check("restart an", 32'(an4),  32'b1110);
        check("restart S",  32'(seg4), 32'b0000001);
        check("restart dp", 32'(dp4),  32'h1);

        run_rows(m_scan_end, m_lz_end, "lz");

        // Single digit, two-cycle slot: lit and blank alternate; each nibble appears one slot after its load.
        rst = 1'b1;
        step();
        rst = 1'b0;
        prev_s = ENC[0];
        for (int n = 0; n < 16; n++) begin
            load1  = 1'b1;
            value1 = 4'(n);
            step();
            load1 = 1'b0;
            check($sformatf("sweep lit an n=%0d", n), 32'(an1),  32'h0);
            check($sformatf("sweep lit S n=%0d", n),  32'(seg1), 32'(prev_s));
            check($sformatf("sweep lit dp n=%0d", n), 32'(dp1),  32'h1);
            step();
            check($sformatf("sweep blank an n=%0d", n), 32'(an1),  32'h1);
            check($sformatf("sweep blank S n=%0d", n),  32'(seg1), 32'(OFF));
            prev_s = ENC[n];
        end
        step();
        check("sweep final an", 32'(an1),  32'h0);
        check("sweep final S",  32'(seg1), 32'(prev_s));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode hexadecimal 7-segment display. It is the parametrised successor of the team's single-digit combinational hex decoder.
- Latches an N-nibble value on a load strobe and scans one digit at a time at a programmable refresh rate.
- Drives the digit anode enables, the shared segment bus and the decimal point.
- Sits between any register or counter producing a hex value and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot including its blank cycle; must be >= 2.
- IDX_W, derived as max(1, clog2(N_DIGITS)); not user-set.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  capture strobe, sampled on clk.
- value  in  4*N_DIGITS  hex nibbles; digit k = value[4k+3:4k]; digit 0 is least significant and rightmost.
- dp_in  in  N_DIGITS  decimal-point request per digit, active-high.
- an  out  N_DIGITS  digit enables, active-low, one-hot-low when driving.
- S  out  7  segments {a,b,c,d,e,f,g}, S[6]=a, S[0]=g, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: prescaler=0, idx=0, shadow value=0, shadow dp=0, an=all ones, S=7'b1111111, dp=1.
- Registered outputs: all outputs are registered. Nothing is driven during reset.
- Load: when load=1 at an edge, shadow<=value and dp_shadow<=dp_in. Outputs reflect new data from the following edge (2-edge latency from load sample to S). No busy signal; a load is legal every cycle.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler==REFRESH_DIV-1).
- Scan index: on tick, idx advances by 1 and wraps from N_DIGITS-1 to 0. With N_DIGITS=1, idx stays 0.
- Output register, tick cycle: an<=all ones, S<=7'b1111111, dp<=1. This is the anti-ghosting blank of exactly 1 cycle per slot.
- Output register, other cycles: an<=~(1<<idx), S<=enc(shadow[idx]), dp<=~dp_shadow[idx].
- Slot timing: each digit is lit for REFRESH_DIV-1 consecutive cycles, followed by 1 blank cycle. Full frame = N_DIGITS*REFRESH_DIV cycles.
- Segment encoding enc, active-low, in order a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - Any X/unknown nibble is encoded as 1111111 (blank).
- Simultaneous load and tick: both take effect on the same edge. The new idx is lit from the new shadow after the blank cycle.
- Reset mid-scan: all outputs go inactive immediately (asynchronously). Scanning restarts at digit 0 with shadow=0. The first lit output is digit 0 showing "0", one edge after rst deasserts.
- Elaboration: N_DIGITS outside 1..8 or REFRESH_DIV<2 is an elaboration error.

Optional Feature:
- Macro: HEX_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - msd = index of the highest nonzero nibble in shadow; msd=0 if shadow==0.
  - Digits with idx>msd are suppressed: an stays all ones, S=1111111, dp=1 for that whole slot.
  - Slot timing is unchanged; no slot is skipped.
  - Exception: a digit whose dp_shadow bit is set is never suppressed.
  - Digit 0 is always shown.
- Undefined: all digits always display their nibble, including leading zeros.

Test Plan (N_DIGITS=4, REFRESH_DIV=4 unless noted):
- Reset then release, no load -> first edge after release: an=1110, S=0000001. Blank (an=1111, S=1111111) every 4th cycle. Digit order 0,1,2,3,0, period 16 cycles.
- load with value=16'hA5C3, dp_in=4'b0100 -> digit 0 S=0000110, digit 1 S=0110001, digit 2 S=0100100 with dp=0, digit 3 S=0001000. S updates 2 edges after load.
- Sweep all 16 nibbles on digit 0 (N_DIGITS=1, REFRESH_DIV=2) -> S matches the enc table each lit cycle. an alternates 0 (lit) and 1 (blank).
- Assert rst mid-slot while digit 2 is lit -> an=1111, S=1111111, dp=1 before the next clock edge. After release, scanning restarts at digit 0 and shows 0.
- load on the same edge as tick, value changing 16'h1111 to 16'h2222 -> blank cycle, then the next digit shows 0010010; no lit cycle shows a mixed old/new value.
- With HEX_SCAN_LEADING_ZERO_BLANK_EN, value=16'h0040, dp_in=4'b1000 -> digits 0 and 1 lit (0000001, 1001100). Digit 2 fully suppressed. Digit 3 lit with S=0000001, dp=0. Without the macro, all four digits are lit.
